sram_dp: RTL and testbench

Parametrised simple dual-port SRAM, successor to the single-port `sram` block. It has:
- independent write and read ports on one clock;
- per-byte write enables;
- configurable registered read latency with a valid strobe;
- defined write-first collision behaviour;
- a post-reset hardware clear sequencer, replacing the array-wide reset loop.

It sits as the storage element under FIFOs and buffers in the verification targets.

---
 rtl/sram_dp.sv | 212 +++++++++++++++++++++
 tb/tb_sram_dp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp.sv
// sram_dp: simple dual-port SRAM with one write port and one read port on a single clock.
// The block provides byte-lane write enables, write-first collisions, and a read latency of
// 1 or 2 with an rd_valid strobe. After reset a clear sequencer zeroes every word.
// Optional feature macro: SRAM_PARITY_EN adds one even-parity bit per byte lane and drives
// par_err. Without the macro, par_err is tied low.
module sram_dp #(
  parameter int unsigned DW     = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned NB    = DW / 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [NB-1:0] wr_be,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          init_busy,
  output logic          par_err
);

  localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          wr_in_range, rd_in_range, run;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [NB-1:0] mem_be;
  logic [DW-1:0] mem_bmask;
  logic          wr_hit, rd_fire;
  logic [DW-1:0] coll_mask;
  logic [DW-1:0] rd_word;
  logic          rd_perr;

  logic          pipe_valid, pipe_perr;
  logic [DW-1:0] pipe_data;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          par_err_q, par_err_d;

  assign run         = (state_q == StRun);
  assign wr_in_range = ({1'b0, wr_addr} < DepthW);
  assign rd_in_range = ({1'b0, rd_addr} < DepthW);
  assign rd_fire     = run & rd_en;
  // Write-first forwarding only applies to a write that will actually land in the array.
  assign wr_hit      = run & wr_en & wr_in_range & (wr_addr == rd_addr);

  // Clear sequencer next state: walk every address once, then hand over to the ports.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end
  end

  // Sequencer state; reset restarts the clear from address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy = (state_q == StInit);

  // Array write port mux: the clear sequencer owns the port while INIT is active.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    mem_be    = wr_be;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (wr_en && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_lane_mask
    assign mem_bmask[8*k +: 8] = {8{mem_be[k]}};
    assign coll_mask[8*k +: 8] = {8{wr_hit & wr_be[k]}};
  end

  // Data array with lane-merged writes; the clear writes all lanes, so no reset is needed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_bmask) | (mem_wdata & mem_bmask);
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wdata_par, mem_wpar, rd_par, word_par;

  for (genvar k = 0; k < NB; k++) begin : g_lane_par
    assign wdata_par[k] = ^wr_data[8*k +: 8];
    assign mem_wpar[k]  = ^mem_wdata[8*k +: 8];
    assign word_par[k]  = ^rd_word[8*k +: 8];
  end

  // Parity array, written alongside the data lanes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_q[mem_waddr] <= (par_q[mem_waddr] & ~mem_be) | (mem_wpar & mem_be);
    end
  end

  // Read merge: forwarded lanes take the new data and its freshly computed parity.
  always_comb begin
    rd_word = '0;
    rd_par  = '0;
    rd_perr = 1'b0;
    if (rd_in_range) begin
      rd_word = (mem_q[rd_addr] & ~coll_mask) | (wr_data & coll_mask);
      rd_par  = (par_q[rd_addr] & ~(wr_be & {NB{wr_hit}})) | (wdata_par & wr_be & {NB{wr_hit}});
      rd_perr = |(word_par ^ rd_par);
    end
  end
`else
  // Read merge: forwarded lanes take the new data; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    rd_perr = 1'b0;
    if (rd_in_range) begin
      rd_word = (mem_q[rd_addr] & ~coll_mask) | (wr_data & coll_mask);
    end
  end
`endif

  if (RD_LAT == 2) begin : g_lat2
    logic          s1_valid_q, s1_valid_d;
    logic          s1_perr_q, s1_perr_d;
    logic [DW-1:0] s1_data_q, s1_data_d;

    // Extra stage: data is captured only on an accepted read; valid and parity move in lockstep.
    always_comb begin
      s1_valid_d = rd_fire;
      s1_perr_d  = rd_fire & rd_perr;
      s1_data_d  = rd_fire ? rd_word : s1_data_q;
    end

    // First read pipeline stage, flushed on reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_valid_q <= 1'b0;
        s1_perr_q  <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_perr_q  <= s1_perr_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign pipe_valid = s1_valid_q;
    assign pipe_perr  = s1_perr_q;
    assign pipe_data  = s1_data_q;
  end else begin : g_lat1
    assign pipe_valid = rd_fire;
    assign pipe_perr  = rd_perr;
    assign pipe_data  = rd_word;
  end

  // Output stage: rd_data holds its last value when no result arrives.
  always_comb begin
    rd_valid_d = pipe_valid;
    rd_data_d  = pipe_valid ? pipe_data : rd_data_q;
    par_err_d  = pipe_valid & pipe_perr;
  end

  // Registered read outputs, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      par_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      par_err_q  <= par_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign par_err  = par_err_q;

endmodule

// File: tb/tb_sram_dp.sv
// Testbench for sram_dp. It runs two instances from shared stimulus:
// - a: DEPTH=16 with RD_LAT=1
// - b: DEPTH=12 with RD_LAT=2, which also exercises out-of-range addresses.
// Expected read results are queued at issue time with the cycle they are due. A monitor pops
// and compares them on every rd_valid.
module tb_sram_dp;

  typedef struct packed {
    logic [15:0] data;
    logic        perr;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid, a_busy, b_busy, a_perr, b_perr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] mdl [2][16];
  logic [1:0]  badm [16];
  logic [15:0] last [2];
  int          dep [2] = '{16, 12};
  int          lat [2] = '{1, 2};

  sram_dp #(.DW(16), .DEPTH(16), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data),
    .rd_valid(a_valid), .init_busy(a_busy), .par_err(a_perr)
  );

  sram_dp #(.DW(16), .DEPTH(12), .RD_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data),
    .rd_valid(b_valid), .init_busy(b_busy), .par_err(b_perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) for (int a = 0; a < 16; a++) mdl[i][a] = 16'h0;
    for (int a = 0; a < 16; a++) badm[a] = 2'b00;
  endtask

  // One cycle of stimulus; the model computes each expected result at issue time.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [1:0] be,
                       input logic [15:0] wd, input logic re, input logic [3:0] ra);
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
    for (int i = 0; i < 2; i++) begin
      exp_t        e;
      logic [15:0] cm;
      cm = 16'h0;
      if (we && wa == ra) cm = {{8{be[1]}}, {8{be[0]}}};
      e.data = 16'h0;
      e.perr = 1'b0;
      e.due  = cyc + lat[i];
      if (re) begin
        if (int'(ra) < dep[i]) begin
          e.data = (mdl[i][ra] & ~cm) | (wd & cm);
          if (i == 0) e.perr = |(badm[ra] & ~{cm[8], cm[0]});
        end
        if (i == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (we && int'(wa) < dep[i]) begin
        if (be[0]) mdl[i][wa][7:0]  = wd[7:0];
        if (be[1]) mdl[i][wa][15:8] = wd[15:8];
        if (i == 0) badm[wa] = badm[wa] & ~be;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 2'b00, 16'h0, 1'b0, 4'h0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) drive(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'(a));
    idle(4);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_a_busy", 32'(a_busy), 32'd1);
    check("rst_b_busy", 32'(b_busy), 32'd1);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_a_data", 32'(a_data), 32'd0);
    check("rst_b_data", 32'(b_data), 32'd0);
    check("rst_perr", 32'({a_perr, b_perr}), 32'd0);
  endtask

  // Release reset and count init_busy cycles; optionally drive port traffic that must be ignored.
  task automatic release_and_count(input logic poke);
    int ca, cb;
    ca = 0; cb = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    if (poke) begin
      wr_en = 1'b1; wr_addr = 4'd3; wr_be = 2'b11; wr_data = 16'hFFFF;
      rd_en = 1'b1; rd_addr = 4'd3;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (a_busy) ca++;
      if (b_busy) cb++;
      if (n == 8) begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
    end
    check("init_len_a", 32'(ca), 32'd16);
    check("init_len_b", 32'(cb), 32'd12);
  endtask

  task automatic mon_port(input int i, input logic v, input logic [15:0] d, input logic pe);
    exp_t e;
    if (v) begin
      if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
        check(i == 0 ? "unexp_valid_a" : "unexp_valid_b", 32'd1, 32'd0);
      end else begin
        e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
        check(i == 0 ? "data_a" : "data_b", 32'(d), 32'(e.data));
        check(i == 0 ? "lat_a" : "lat_b", 32'(cyc), 32'(e.due));
        check(i == 0 ? "perr_a" : "perr_b", 32'(pe), 32'(e.perr));
      end
      last[i] = d;
    end else begin
      check(i == 0 ? "hold_a" : "hold_b", 32'(d), 32'(last[i]));
      check(i == 0 ? "perr_idle_a" : "perr_idle_b", 32'(pe), 32'd0);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      last[0] = 16'h0;
      last[1] = 16'h0;
    end else begin
      mon_port(0, a_valid, a_data, a_perr);
      mon_port(1, b_valid, b_data, b_perr);
    end
  end

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = 4'h0; wr_be = 2'b00; wr_data = 16'h0; rd_en = 1'b0; rd_addr = 4'h0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_state();
    release_and_count(1'b1);
    read_all();

    // Lane-masked writes, write-first collision, out-of-range, wr_be=0 no-op.
    drive(1'b1, 4'd3, 2'b11, 16'hA55A, 1'b0, 4'd0);
    drive(1'b1, 4'd3, 2'b10, 16'h12CD, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3);
    drive(1'b1, 4'd5, 2'b11, 16'h1234, 1'b0, 4'd0);
    drive(1'b1, 4'd5, 2'b01, 16'hBEEF, 1'b1, 4'd5);
    drive(1'b1, 4'd13, 2'b11, 16'hCAFE, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd13);
    drive(1'b1, 4'd7, 2'b00, 16'hFFFF, 1'b1, 4'd7);
    // Back-to-back reads; the write one cycle after the read of address 2 must not show.
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd2);
    drive(1'b1, 4'd2, 2'b11, 16'h7777, 1'b1, 4'd0);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd1);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd2);
    idle(4);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] wa, ra;
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      drive(1'($urandom), wa, 2'($urandom), 16'($urandom), 1'($urandom), ra);
    end
    idle(4);

`ifdef SRAM_PARITY_EN
    drive(1'b1, 4'd9, 2'b11, 16'h5A3C, 1'b0, 4'd0);
    idle(2);
    @(posedge clk);
    #1;
    dut_a.mem_q[9][0] = ~dut_a.mem_q[9][0];
    mdl[0][9][0] = ~mdl[0][9][0];
    badm[9] = 2'b01;
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd9);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd8);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd9);
    drive(1'b1, 4'd9, 2'b01, 16'h0011, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd9);
    idle(4);
`endif

    // Fill with ones, then reset in the middle of the clear and check it restarts fully.
    for (int a = 0; a < 16; a++) drive(1'b1, 4'(a), 2'b11, 16'hFFFF, 1'b0, 4'd0);
    idle(4);
    check("drain_a", 32'(q_a.size()), 32'd0);
    check("drain_b", 32'(q_b.size()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check_reset_state();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();
    release_and_count(1'b0);
    read_all();

    check("final_a", 32'(q_a.size()), 32'd0);
    check("final_b", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
